// File: rtl/m_rect_fill_pkg.sv
// -----------------------------------------------------------------------------
// m_rect_fill_pkg
// Shared definitions for the rectangle-fill engine and the display controller:
// visible screen size, fill-engine state encoding and small unsigned helpers.
// -----------------------------------------------------------------------------
package m_rect_fill_pkg;

   // Visible screen size in pixels. Video memory itself is 256x256.
   localparam int P_W = 240;
   localparam int P_H = 240;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CLIP = 2'd1,
      ST_FILL = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic logic [7:0] u8_min(input logic [7:0] a, input logic [7:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [7:0] u8_max(input logic [7:0] a, input logic [7:0] b);
      return (a < b) ? b : a;
   endfunction

endpackage

// File: rtl/m_rect_fill.sv
// -----------------------------------------------------------------------------
// m_rect_fill
// Fills an axis-aligned rectangle of video memory with one RGB565 colour.
// A command gives two arbitrary corners; the block orders them, clips the
// rectangle to the visible area and emits one write per pixel in raster order.
//
// Ports
//   w_clk, w_rst_n          clock, asynchronous active-low reset
//   w_cmd_valid/ready       command handshake (ready only while idle)
//   w_cmd_x0/y0/x1/y1       rectangle corners, any order
//   w_cmd_color             fill colour (RGB565)
//   w_stall                 writer back-pressure; current write is held
//   r_st_we/wadr/wdata      video-memory write port, wadr = {y, x}
//   w_busy                  high whenever not idle
//   r_done                  one-cycle pulse when a command has finished
// -----------------------------------------------------------------------------
module m_rect_fill #(
   parameter int P_W = m_rect_fill_pkg::P_W,
   parameter int P_H = m_rect_fill_pkg::P_H
) (
   input  logic        w_clk,
   input  logic        w_rst_n,
   input  logic        w_cmd_valid,
   output logic        w_cmd_ready,
   input  logic [7:0]  w_cmd_x0,
   input  logic [7:0]  w_cmd_y0,
   input  logic [7:0]  w_cmd_x1,
   input  logic [7:0]  w_cmd_y1,
   input  logic [15:0] w_cmd_color,
   input  logic        w_stall,
   output logic        r_st_we,
   output logic [15:0] r_st_wadr,
   output logic [15:0] r_st_wdata,
   output logic        w_busy,
   output logic        r_done
);
   import m_rect_fill_pkg::*;

   localparam logic [7:0] C_XMAX = 8'(P_W - 1);
   localparam logic [7:0] C_YMAX = 8'(P_H - 1);

   state_t      state_q, state_d;
   logic [7:0]  cx0_q, cx0_d, cy0_q, cy0_d, cx1_q, cx1_d, cy1_q, cy1_d;
   logic [15:0] color_q, color_d;
   logic [7:0]  xl_q, xl_d, xh_q, xh_d, yh_q, yh_d;
   logic [7:0]  x_q, x_d, y_q, y_d;
   logic        we_q, we_d;
   logic        done_q, done_d;

   // Ordered and clipped bounds of the captured command (used in CLIP only).
   logic [7:0]  ord_xl, ord_xh, ord_yl, ord_yh;
   logic [7:0]  clp_xh, clp_yh;
   logic        clip_empty;

   assign ord_xl = u8_min(cx0_q, cx1_q);
   assign ord_xh = u8_max(cx0_q, cx1_q);
   assign ord_yl = u8_min(cy0_q, cy1_q);
   assign ord_yh = u8_max(cy0_q, cy1_q);

   assign clp_xh = (ord_xh > C_XMAX) ? C_XMAX : ord_xh;
   assign clp_yh = (ord_yh > C_YMAX) ? C_YMAX : ord_yh;

   // Entirely off-screen: the low corner is already past the visible edge.
   assign clip_empty = (ord_xl > C_XMAX) || (ord_yl > C_YMAX);

   // Ready is masked while reset is held so nothing looks acceptable then.
   assign w_cmd_ready = (state_q == ST_IDLE) && w_rst_n;
   assign w_busy      = (state_q != ST_IDLE);
   assign r_st_we     = we_q;
   assign r_st_wadr   = {y_q, x_q};
   assign r_st_wdata  = color_q;
   assign r_done      = done_q;

   always_comb begin
      state_d = state_q;
      cx0_d   = cx0_q;
      cy0_d   = cy0_q;
      cx1_d   = cx1_q;
      cy1_d   = cy1_q;
      color_d = color_q;
      xl_d    = xl_q;
      xh_d    = xh_q;
      yh_d    = yh_q;
      x_d     = x_q;
      y_d     = y_q;
      we_d    = we_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (w_cmd_valid && w_cmd_ready) begin
               cx0_d   = w_cmd_x0;
               cy0_d   = w_cmd_y0;
               cx1_d   = w_cmd_x1;
               cy1_d   = w_cmd_y1;
               color_d = w_cmd_color;
               state_d = ST_CLIP;
            end
         end
         ST_CLIP: begin
            if (clip_empty) begin
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               xl_d    = ord_xl;
               xh_d    = clp_xh;
               yh_d    = clp_yh;
               x_d     = ord_xl;
               y_d     = ord_yl;
               we_d    = 1'b1;
               state_d = ST_FILL;
            end
         end
         ST_FILL: begin
            // we_q is always high here; a write retires on every unstalled edge.
            if (!w_stall) begin
               if (x_q == xh_q) begin
                  if (y_q == yh_q) begin
                     we_d    = 1'b0;
                     done_d  = 1'b1;
                     state_d = ST_DONE;
                  end else begin
                     x_d = xl_q;
                     y_d = y_q + 8'd1;
                  end
               end else begin
                  x_d = x_q + 8'd1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state_q <= ST_IDLE;
         cx0_q   <= '0;
         cy0_q   <= '0;
         cx1_q   <= '0;
         cy1_q   <= '0;
         color_q <= '0;
         xl_q    <= '0;
         xh_q    <= '0;
         yh_q    <= '0;
         x_q     <= '0;
         y_q     <= '0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cx0_q   <= cx0_d;
         cy0_q   <= cy0_d;
         cx1_q   <= cx1_d;
         cy1_q   <= cy1_d;
         color_q <= color_d;
         xl_q    <= xl_d;
         xh_q    <= xh_d;
         yh_q    <= yh_d;
         x_q     <= x_d;
         y_q     <= y_d;
         we_q    <= we_d;
         done_q  <= done_d;
      end
   end

endmodule
